// File: rtl/sbox_seq_pkg.sv
// Shared types and constants for the nibble-serial S-box word sequencer.
package sbox_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sbox_word_sequencer_if.sv
// Word-in / word-out valid-ready bundle of the S-box word sequencer.
interface sbox_word_sequencer_if #(
  parameter int unsigned WORD_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sbox_word_sequencer.sv
// Feeds a word nibble-by-nibble (LSB first) through an external registered
// 4-bit S-box and reassembles the substituted word.
module sbox_word_sequencer
  import sbox_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  sbox_word_sequencer_if.slave bus,
  output logic [NIB_W-1:0] sb_in,
  input  logic [NIB_W-1:0] sb_out
);

  localparam int unsigned NIB   = WORD_W / NIB_W;
  localparam int unsigned CNT_W = $clog2(NIB + 1);
  localparam logic [CNT_W-1:0] LAST_FEED = CNT_W'(NIB - 1);

  seq_state_t        state, state_d;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] result;
  logic [CNT_W-1:0]  cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept;
  logic              shift_en;
  logic              capture;

  // The S-box adds one cycle, so capture trails the feed by one edge:
  // skip the first FEED edge and take the DRAIN edge instead.
  always_comb begin
    state_d  = state;
    accept   = '0;
    shift_en = '0;
    capture  = '0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept  = '1;
          state_d = FEED;
        end
      end
      FEED: begin
        shift_en = '1;
        capture  = (cnt != '0);
        if (cnt == LAST_FEED) state_d = DRAIN;
      end
      DRAIN: begin
        capture = '1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      result      <= '0;
      cnt         <= '0;
      in_ready_q  <= '0;
      out_valid_q <= '0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
      if (accept) begin
        shift_reg <= bus.in_data;
        cnt       <= '0;
      end else if (shift_en) begin
        shift_reg <= shift_reg >> NIB_W;
        cnt       <= cnt + 1'b1;
      end
      if (capture) result <= {sb_out, result[WORD_W-1:NIB_W]};
    end
  end

  assign sb_in         = (state == FEED) ? shift_reg[NIB_W-1:0] : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = result;

endmodule

// File: tb/tb_sbox_word_sequencer.sv
// Self-checking bench for sbox_word_sequencer with a behavioural registered S-box beside it.
module tb_sbox_word_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sb_in;
  logic [3:0] sb_out;

  sbox_word_sequencer_if #(.WORD_W(32)) bus ();

  sbox_word_sequencer #(.WORD_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sb_in  (sb_in),
    .sb_out (sb_out)
  );

  int n_checks;
  int n_pass;

  // 0 = identity, 1 = complement, 2 = table permutation
  int         sb_mode;
  logic [3:0] sb_table [16];
  logic [3:0] seq_obs [9];

  function automatic logic [3:0] sbox_f(input logic [3:0] x);
    case (sb_mode)
      0:       return x;
      1:       return ~x;
      default: return sb_table[x];
    endcase
  endfunction

  always @(posedge clk) sb_out <= sbox_f(sb_in);

  function automatic logic [31:0] ref_sub(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = sbox_f(w[4*k +: 4]);
    return r;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one word and waits for out_valid; leaves out_ready as the caller set it.
  task automatic send_word(input logic [31:0] w, output int lat, output logic [31:0] res);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = ~w;
    lat = -1;
    res = '0;
    for (int e = 1; e <= 40; e++) begin
      if (e <= 9) seq_obs[e-1] = sb_in;
      if (e == 4) bus.in_data = $urandom;
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = e;
        res = bus.out_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got=%h exp=0", bus.out_data); else n_pass++;
    n_checks++; if (sb_in !== 4'h0) $display("FAIL reset_sb_in got=%h exp=0", sb_in); else n_pass++;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_identity();
    int          lat;
    logic [31:0] res;
    logic [31:0] w;
    w = 32'h01234567;
    sb_mode = 0;
    bus.out_ready = 1'b1;
    send_word(w, lat, res);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (seq_obs[k] !== 4'((w >> (4*k)) & 32'hF))
        $display("FAIL ident_sb_in[%0d] got=%h exp=%h", k, seq_obs[k], 4'((w >> (4*k)) & 32'hF));
      else n_pass++;
    end
    n_checks++; if (seq_obs[8] !== 4'h0) $display("FAIL drain_sb_in got=%h exp=0", seq_obs[8]); else n_pass++;
    n_checks++; if (lat !== 9) $display("FAIL ident_latency got=%0d exp=9", lat); else n_pass++;
    n_checks++; if (res !== 32'h01234567) $display("FAIL ident_out_data got=%h exp=01234567", res); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL ident_valid_drop got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL ident_ready_back got=%b exp=1", bus.in_ready); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_complement();
    int          lat;
    logic [31:0] res;
    sb_mode = 1;
    bus.out_ready = 1'b1;
    send_word(32'h01234567, lat, res);
    n_checks++; if (lat !== 9) $display("FAIL compl_latency got=%0d exp=9", lat); else n_pass++;
    n_checks++; if (res !== 32'hFEDCBA98) $display("FAIL compl_out_data got=%h exp=FEDCBA98", res); else n_pass++;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold();
    int          lat;
    logic [31:0] res;
    logic [31:0] w;
    logic [31:0] exp;
    sb_mode = 2;
    w = $urandom;
    exp = ref_sub(w);
    bus.out_ready = 1'b0;
    send_word(w, lat, res);
    n_checks++; if (res !== exp) $display("FAIL hold_out_data got=%h exp=%h", res, exp); else n_pass++;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = $urandom;
      tick();
      n_checks++; if (bus.out_data !== exp) $display("FAIL hold_stable[%0d] got=%h exp=%h", i, bus.out_data, exp); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, bus.in_ready); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL hold_valid[%0d] got=%b exp=1", i, bus.out_valid); else n_pass++;
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL hold_release_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL hold_release_ready got=%b exp=1", bus.in_ready); else n_pass++;
    n_checks++; if (sb_in !== 4'h0) $display("FAIL hold_release_sb_in got=%h exp=0", sb_in); else n_pass++;
  endtask

  task automatic test_reset_mid_feed();
    int          lat;
    logic [31:0] res;
    sb_mode = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h12345678;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 32'h0) $display("FAIL midrst_out_data got=%h exp=0", bus.out_data); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++; if (sb_in !== 4'h0) $display("FAIL midrst_sb_in got=%h exp=0", sb_in); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    send_word(32'hA5A5A5A5, lat, res);
    n_checks++; if (lat !== 9) $display("FAIL midrst_latency got=%0d exp=9", lat); else n_pass++;
    n_checks++; if (res !== 32'hA5A5A5A5) $display("FAIL midrst_out_data got=%h exp=A5A5A5A5", res); else n_pass++;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2, res1, res2;
    logic        got1, take;
    int          acc2, lat2, guard;
    sb_mode = 2;
    w1 = $urandom;
    w2 = $urandom;
    got1 = 1'b0;
    res1 = '0;
    res2 = '0;
    acc2 = -1;
    lat2 = -1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = w1;
    tick();
    bus.in_data = w2;
    for (int e = 1; e <= 30; e++) begin
      take = (bus.in_ready === 1'b1);
      tick();
      if (bus.out_valid === 1'b1 && !got1) begin
        got1 = 1'b1;
        res1 = bus.out_data;
      end
      if (take) begin
        acc2 = e;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data = $urandom;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat2 = e;
        res2 = bus.out_data;
        break;
      end
    end
    n_checks++; if (acc2 !== 11) $display("FAIL b2b_accept_gap got=%0d exp=11", acc2); else n_pass++;
    n_checks++; if (res1 !== ref_sub(w1)) $display("FAIL b2b_word1 got=%h exp=%h", res1, ref_sub(w1)); else n_pass++;
    n_checks++; if (lat2 !== 9) $display("FAIL b2b_latency2 got=%0d exp=9", lat2); else n_pass++;
    n_checks++; if (res2 !== ref_sub(w2)) $display("FAIL b2b_word2 got=%h exp=%h", res2, ref_sub(w2)); else n_pass++;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int          lat, stall;
    logic [31:0] res, w;
    for (int i = 0; i < 10; i++) begin
      sb_mode = $urandom_range(0, 2);
      w = $urandom;
      stall = $urandom_range(0, 3);
      bus.out_ready = (stall == 0);
      send_word(w, lat, res);
      n_checks++; if (lat !== 9) $display("FAIL rand_latency[%0d] got=%0d exp=9", i, lat); else n_pass++;
      n_checks++; if (res !== ref_sub(w)) $display("FAIL rand_out_data[%0d] got=%h exp=%h", i, res, ref_sub(w)); else n_pass++;
      for (int s = 0; s < stall; s++) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rand_valid_drop[%0d] got=%b exp=0", i, bus.out_valid); else n_pass++;
    end
  endtask

  initial begin
    logic [3:0] tmp;
    int         j;
    n_checks = 0;
    n_pass = 0;
    sb_mode = 0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sb_table[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = sb_table[i];
      sb_table[i] = sb_table[j];
      sb_table[j] = tmp;
    end
    test_reset();
    test_identity();
    test_complement();
    test_hold();
    test_reset_mid_feed();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
